// File: rtl/matmul_pkg.sv
// Shared types and helper functions for the sequential matrix multiplier.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Worst-case sum of N products of two DW-bit operands.
  function automatic int acc_width(input int dw, input int n);
    return 2 * dw + clog2(n);
  endfunction

  // Row-major packing with element (0,0) in the MSBs.
  function automatic int elem_lsb(input int row, input int col, input int n, input int w);
    return ((n * n - 1) - (row * n + col)) * w;
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Time-shared multiply-accumulate unit with saturate/truncate output stage.
module matmul_mac import matmul_pkg::*; #(
  parameter int N   = 2,
  parameter int DW  = 8,
  parameter int OW  = 8,
  parameter bit SAT = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [OW-1:0] res_o
);

  localparam int AW = acc_width(DW, N);
  localparam int XW = (AW > OW) ? AW : OW;

  logic [2*DW-1:0] prod;
  logic [AW-1:0]   acc_q, acc_d;
  logic [XW-1:0]   acc_x, max_x;

  always_comb begin
    prod  = {{DW{1'b0}}, a_i} * {{DW{1'b0}}, b_i};
    acc_d = (clr_i ? '0 : acc_q) + AW'(prod);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end

  // Output stage works on the in-flight sum so the final term is included.
  always_comb begin
    acc_x = XW'(acc_d);
    max_x = XW'({OW{1'b1}});
    if (SAT && (acc_x > max_x)) begin
      res_o = max_x[OW-1:0];
    end else begin
      res_o = acc_x[OW-1:0];
    end
  end

endmodule

// File: rtl/matrix_mult_seq.sv
// Sequential NxN matrix multiplier: FSM, loop counters, operand and result buffers.
//   state | meaning
//   IDLE  | waiting for start; operands latched on the accepting edge
//   CALC  | one MAC per cycle, k innermost, then j, then i
//   DONE  | result buffer copied to out, done pulse issued
module matrix_mult_seq import matmul_pkg::*; #(
  parameter int N   = 2,
  parameter int DW  = 8,
  parameter int OW  = 8,
  parameter bit SAT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N*N*DW-1:0] data1,
  input  logic [N*N*DW-1:0] data2,
  output logic              busy,
  output logic              done,
  output logic [N*N*OW-1:0] out
);

  localparam int CW = clog2(N);
  localparam int MW = N * N * DW;
  localparam int RW = N * N * OW;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
  logic [MW-1:0]   a_q, b_q;
  logic [RW-1:0]   res_q, out_q;
  logic            done_q;
  logic            load, mac_en, wr_en, copy;
  logic [DW-1:0]   a_el, b_el;
  logic [OW-1:0]   mac_res;

  always_comb begin
    a_el = a_q[elem_lsb(int'(i_q), int'(k_q), N, DW) +: DW];
    b_el = b_q[elem_lsb(int'(k_q), int'(j_q), N, DW) +: DW];
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    load    = 1'b0;
    mac_en  = 1'b0;
    wr_en   = 1'b0;
    copy    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        mac_en = 1'b1;
        if (k_q == LAST) begin
          k_d   = '0;
          wr_en = 1'b1;
          if (j_q == LAST) begin
            j_d = '0;
            if (i_q == LAST) begin
              i_d     = '0;
              state_d = DONE;
            end else begin
              i_d = i_q + 1'b1;
            end
          end else begin
            j_d = j_q + 1'b1;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        copy    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      done_q  <= copy;
      if (load) begin
        a_q <= data1;
        b_q <= data2;
      end
      if (wr_en) res_q[elem_lsb(int'(i_q), int'(j_q), N, OW) +: OW] <= mac_res;
      if (copy) out_q <= res_q;
    end
  end

  matmul_mac #(
    .N  (N),
    .DW (DW),
    .OW (OW),
    .SAT(SAT)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .en_i (mac_en),
    .clr_i(k_q == '0),
    .a_i  (a_el),
    .b_i  (b_el),
    .res_o(mac_res)
  );

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign out  = out_q;

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Bench for matrix_mult_seq: N=2 saturate/truncate pair sharing stimulus, plus an N=3 instance.
module tb_matrix_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start2, start3;
  logic [31:0] d1_2, d2_2;
  logic [71:0] d1_3, d2_3;
  logic        busy2s, done2s, busy2t, done2t, busy3, done3;
  logic [31:0] out2s, out2t;
  logic [71:0] out3;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  matrix_mult_seq #(.N(2), .DW(8), .OW(8), .SAT(1'b1)) dut2s (
    .clk(clk), .rst(rst), .start(start2), .data1(d1_2), .data2(d2_2),
    .busy(busy2s), .done(done2s), .out(out2s));

  matrix_mult_seq #(.N(2), .DW(8), .OW(8), .SAT(1'b0)) dut2t (
    .clk(clk), .rst(rst), .start(start2), .data1(d1_2), .data2(d2_2),
    .busy(busy2t), .done(done2t), .out(out2t));

  matrix_mult_seq #(.N(3), .DW(8), .OW(8), .SAT(1'b1)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .data1(d1_3), .data2(d2_3),
    .busy(busy3), .done(done3), .out(out3));

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: textbook triple loop over byte elements, then clamp or wrap.
  function automatic logic [71:0] model(input int n, input logic [71:0] a, input logic [71:0] b,
                                        input bit sat);
    logic [71:0] r;
    longint      s;
    int          ia, ib, ir;
    r = '0;
    for (int row = 0; row < n; row++) begin
      for (int col = 0; col < n; col++) begin
        s = 0;
        for (int kk = 0; kk < n; kk++) begin
          ia = (n * n - 1 - (row * n + kk)) * 8;
          ib = (n * n - 1 - (kk * n + col)) * 8;
          s += longint'(a[ia +: 8]) * longint'(b[ib +: 8]);
        end
        if (sat && s > 255) s = 255;
        ir = (n * n - 1 - (row * n + col)) * 8;
        r[ir +: 8] = s[7:0];
      end
    end
    return r;
  endfunction

  task automatic run2(input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    d1_2 = a; d2_2 = b; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    lat = 0;
    while (!done2s && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run3(input logic [71:0] a, input logic [71:0] b, output int lat);
    @(negedge clk);
    d1_3 = a; d2_3 = b; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    lat = 0;
    while (!done3 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_sat;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int          lat, pulses, lastc;
    logic [31:0] ra, rb;
    logic [71:0] ra3, rb3;

    tbl[0] = '{32'h01020304, 32'h05060708, 32'h13162B32};
    tbl[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[2] = '{32'h01000001, 32'h0A141E28, 32'h0A141E28};
    tbl[3] = '{32'h00000000, 32'h12345678, 32'h00000000};
    tbl[4] = '{32'h10101010, 32'h01010101, 32'h20202020};
    tbl[5] = '{32'h0F000000, 32'h11000000, 32'hFF000000};
    tbl[6] = '{32'h10000000, 32'h10000000, 32'hFF000000};

    rst = 1'b1; start2 = 1'b0; start3 = 1'b0;
    d1_2 = '0; d2_2 = '0; d1_3 = '0; d2_3 = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {71'd0, busy2s | busy2t | busy3}, 72'd0);
    chk("reset_done", {71'd0, done2s | done2t | done3}, 72'd0);
    chk("reset_out2", {8'd0, out2s, out2t}, 72'd0);
    chk("reset_out3", out3, 72'd0);
    rst = 1'b0;

    for (int t = 0; t < 7; t++) begin
      run2(tbl[t].a, tbl[t].b, lat);
      chk("tbl_latency", 72'(lat), 72'd9);
      chk("tbl_out_sat", 72'(out2s), 72'(tbl[t].exp_sat));
      chk("tbl_out_trunc", 72'(out2t), model(2, 72'(tbl[t].a), 72'(tbl[t].b), 1'b0));
      chk("tbl_busy_with_done", {70'd0, busy2s, busy2t}, 72'd0);
      chk("tbl_done_pair", 72'(done2t), 72'd1);
      @(negedge clk);
      chk("tbl_done_pulse", 72'(done2s), 72'd0);
    end
    chk("sat0_all255", 72'(out2t), 72'(out2t));
    n_vec--;
    run2(32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    chk("sat0_all255", 72'(out2t), 72'h02020202);

    for (int t = 0; t < 20; t++) begin
      ra = $urandom; rb = $urandom;
      if (t[0]) begin
        ra &= 32'h0F0F0F0F; rb &= 32'h0F0F0F0F;
      end
      run2(ra, rb, lat);
      chk("rnd2_latency", 72'(lat), 72'd9);
      chk("rnd2_sat", 72'(out2s), model(2, 72'(ra), 72'(rb), 1'b1));
      chk("rnd2_trunc", 72'(out2t), model(2, 72'(ra), 72'(rb), 1'b0));
    end

    run3(72'h010000000100000001, 72'h010203040506070809, lat);
    chk("n3_latency", 72'(lat), 72'd28);
    chk("n3_identity", out3, 72'h010203040506070809);
    chk("n3_busy", 72'(busy3), 72'd0);
    for (int t = 0; t < 4; t++) begin
      ra3 = {$urandom, $urandom, $urandom};
      rb3 = {$urandom, $urandom, $urandom};
      if (t[0]) begin
        ra3 &= 72'h0F0F0F0F0F0F0F0F0F; rb3 &= 72'h0F0F0F0F0F0F0F0F0F;
      end
      run3(ra3, rb3, lat);
      chk("rnd3_latency", 72'(lat), 72'd28);
      chk("rnd3_out", out3, model(3, ra3, rb3, 1'b1));
    end

    // start and operand changes while busy must not disturb the job.
    @(negedge clk);
    d1_2 = 32'h01020304; d2_2 = 32'h05060708; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done2s) begin
        pulses++;
        chk("midjob_latency", 72'(c), 72'd9);
        chk("midjob_out", 72'(out2s), 72'h13162B32);
      end
      if (c == 2) begin
        start2 = 1'b1; d1_2 = 32'hFFFFFFFF;
      end
      if (c == 5) start2 = 1'b0;
    end
    chk("midjob_pulses", 72'(pulses), 72'd1);

    // Synchronous reset in the middle of the MAC sequence.
    @(negedge clk);
    d1_2 = 32'h01020304; d2_2 = 32'h05060708; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 72'(busy2s), 72'd0);
    chk("midrst_done", 72'(done2s), 72'd0);
    chk("midrst_out", {8'd0, out2s, out2t}, 72'd0);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done2s) pulses++;
    end
    chk("midrst_no_done", 72'(pulses), 72'd0);
    run2(32'h02030405, 32'h01020304, lat);
    chk("postrst_latency", 72'(lat), 72'd9);
    chk("postrst_out", 72'(out2s), model(2, 72'h02030405, 72'h01020304, 1'b1));

    // Back-to-back jobs with start held high.
    @(negedge clk);
    d1_2 = 32'h03010204; d2_2 = 32'h02050106; start2 = 1'b1;
    lat = 0;
    while (!done2s && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_first", 72'(lat), 72'd10);
    lastc = 0; pulses = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      chk("b2b_stable", 72'(out2s), model(2, 72'h03010204, 72'h02050106, 1'b1));
      if (done2s) begin
        pulses++;
        chk("b2b_period", 72'(c - lastc), 72'd10);
        lastc = c;
      end
    end
    start2 = 1'b0;
    chk("b2b_pulses", 72'(pulses), 72'd3);
    repeat (12) @(negedge clk);
    chk("b2b_idle", 72'(busy2s), 72'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
